bitstream_decoder: RTL

- Downstream consumer of the stochastic bitstream pair (p/m) produced by the bitstream generator stage.
- Integrates signed bits (+1 on p, −1 on m) over a fixed window of 2^WINDOW_LOG2 enabled cycles.
- Publishes the window sum as a signed fixed-point estimate through a valid/ready handshake.
- Used for readback, debug and converting stochastic results back to binary.

---
 rtl/stochastic_pkg.sv | 11 +
 rtl/bitstream_decoder_if.sv | 13 +
 rtl/bitstream_window_acc.sv | 37 +++
 rtl/bitstream_decoder.sv | 49 ++++
 4 files changed

// File: rtl/stochastic_pkg.sv
// stochastic_pkg: shared window-length helper, signed delta type and bit-pair decode
package stochastic_pkg;
  localparam int OUT_MARGIN = 2;
  typedef logic signed [1:0] delta_t;
  function automatic int unsigned window_len(input int unsigned log2);
    return 32'd1 << log2;
  endfunction
  function automatic delta_t decode_delta(input logic p, input logic m);
    return (p & ~m) ? 2'sb01 : (m & ~p) ? 2'sb11 : 2'sb00;
  endfunction
endpackage

// File: rtl/bitstream_decoder_if.sv
// bitstream_decoder_if: sample inputs plus the est valid/ready result channel
interface bitstream_decoder_if #(parameter int OUT_WIDTH = 12);
  logic en;
  logic clear;
  logic in_p;
  logic in_m;
  logic signed [OUT_WIDTH-1:0] est;
  logic est_valid;
  logic est_ready;
  logic overrun;
  modport master (input en, clear, in_p, in_m, est_ready, output est, est_valid, overrun);
  modport slave (output en, clear, in_p, in_m, est_ready, input est, est_valid, overrun);
endinterface

// File: rtl/bitstream_window_acc.sv
// bitstream_window_acc: integrates +1/-1 samples over 2^WINDOW_LOG2 enabled cycles
module bitstream_window_acc
  import stochastic_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic clear,
  input  logic in_p,
  input  logic in_m,
  output logic done,
  output logic signed [WINDOW_LOG2+OUT_MARGIN-1:0] sum
);
  localparam int ACC_W = WINDOW_LOG2 + OUT_MARGIN;
  localparam logic [WINDOW_LOG2-1:0] LAST = WINDOW_LOG2'(window_len(WINDOW_LOG2) - 1);
  logic signed [ACC_W-1:0] acc;
  logic [WINDOW_LOG2-1:0] win_cnt;
  delta_t delta;
  assign delta = decode_delta(in_p, in_m);
  // sum includes the current sample so the final cycle's bit lands in the result
  assign sum = acc + ACC_W'(delta);
  assign done = en && !clear && win_cnt == LAST;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc <= '0;
      win_cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      win_cnt <= '0;
    end else if (en) begin
      acc <= done ? '0 : sum;
      win_cnt <= win_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: windowed p/m bitstream integrator publishing a signed estimate
module bitstream_decoder
  import stochastic_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10,
  parameter int OUT_WIDTH = WINDOW_LOG2 + 2
) (
  input logic CLK,
  input logic nRST,
  bitstream_decoder_if.master bus
);
  if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > 30) begin : g_bad_window
    $error("bitstream_decoder: WINDOW_LOG2 must be in 1..30");
  end
  if (OUT_WIDTH < WINDOW_LOG2 + OUT_MARGIN) begin : g_bad_width
    $error("bitstream_decoder: OUT_WIDTH must be at least WINDOW_LOG2+2");
  end
  logic done;
  logic signed [WINDOW_LOG2+OUT_MARGIN-1:0] sum;
  bitstream_window_acc #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc (
    .CLK(CLK),
    .nRST(nRST),
    .en(bus.en),
    .clear(bus.clear),
    .in_p(bus.in_p),
    .in_m(bus.in_m),
    .done(done),
    .sum(sum)
  );
  // a completing window always wins over acceptance; overrun only if the old result was never taken
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.est <= '0;
      bus.est_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else if (bus.clear) begin
      bus.est_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= done && bus.est_valid && !bus.est_ready;
      if (done) begin
        bus.est <= OUT_WIDTH'(sum);
        bus.est_valid <= 1'b1;
      end else if (bus.est_valid && bus.est_ready) begin
        bus.est_valid <= 1'b0;
      end
    end
  end
endmodule
